// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock)
// with valid/ready handshakes, signed input, overflow flag and leading-zero mask.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 5
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_data,
  input  logic                  in_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_neg,
  output logic                  out_ovf,
  output logic [DIGITS-1:0]     out_blank
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  if (BIN_W < 2 || DIGITS < 1) begin : g_param_err
    $error("bin_to_bcd_seq: BIN_W must be >= 2 and DIGITS >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q,     state_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [BCD_W-1:0]    acc_q,       acc_d;
  logic [BIN_W-1:0]    mag_q,       mag_d;
  logic                neg_q,       neg_d;
  logic                sticky_q,    sticky_d;
  logic                ovalid_q,    ovalid_d;
  logic [BCD_W-1:0]    obcd_q,      obcd_d;
  logic                oneg_q,      oneg_d;
  logic                oovf_q,      oovf_d;
  logic [DIGITS-1:0]   oblank_q,    oblank_d;

  logic [BCD_W-1:0]    adj_s;
  logic [BCD_W-1:0]    acc_shift_s;
  logic                sticky_shift_s;

  // Add 3 to every digit above 4 before the shift (4-bit, carry discarded).
  function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] a);
    logic [BCD_W-1:0] r;
    logic [3:0]       dig;
    r = a;
    for (int i = 0; i < DIGITS; i++) begin
      dig = a[4*i +: 4];
      r[4*i +: 4] = (dig > 4'd4) ? dig + 4'd3 : dig;
    end
    return r;
  endfunction

  // Digit i is blank when it and every more significant digit are zero; units never blank.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] a);
    logic [DIGITS-1:0] m;
    logic              nz;
    m  = '0;
    nz = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      nz   = nz | (a[4*i +: 4] != 4'd0);
      m[i] = ~nz;
    end
    return m;
  endfunction

  // One double-dabble step on the current accumulator.
  always_comb begin
    adj_s          = dabble_adj(acc_q);
    acc_shift_s    = {adj_s[BCD_W-2:0], mag_q[BIN_W-1]};
    sticky_shift_s = sticky_q | adj_s[BCD_W-1];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mag_d    = mag_q;
    neg_d    = neg_q;
    sticky_d = sticky_q;
    ovalid_d = ovalid_q;
    obcd_d   = obcd_q;
    oneg_d   = oneg_q;
    oovf_d   = oovf_q;
    oblank_d = oblank_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = CONV;
          cnt_d    = '0;
          acc_d    = '0;
          sticky_d = 1'b0;
          if (in_signed && in_data[BIN_W-1]) begin
            mag_d = ~in_data + BIN_W'(1);
            neg_d = 1'b1;
          end else begin
            mag_d = in_data;
            neg_d = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        acc_d    = acc_shift_s;
        mag_d    = {mag_q[BIN_W-2:0], 1'b0};
        sticky_d = sticky_shift_s;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d  = DONE;
          obcd_d   = acc_shift_s;
          oneg_d   = neg_q;
          oovf_d   = sticky_shift_s;
          oblank_d = blank_mask(acc_shift_s);
          ovalid_d = 1'b1;
        end else begin
          state_d = CONV;
        end
      end
      DONE: begin
        if (out_ready) begin
          ovalid_d = 1'b0;
          state_d  = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d  = IDLE;
        ovalid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mag_q    <= '0;
      neg_q    <= 1'b0;
      sticky_q <= 1'b0;
      ovalid_q <= 1'b0;
      obcd_q   <= '0;
      oneg_q   <= 1'b0;
      oovf_q   <= 1'b0;
      oblank_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mag_q    <= mag_d;
      neg_q    <= neg_d;
      sticky_q <= sticky_d;
      ovalid_q <= ovalid_d;
      obcd_q   <= obcd_d;
      oneg_q   <= oneg_d;
      oovf_q   <= oovf_d;
      oblank_q <= oblank_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = ovalid_q;
  assign out_bcd   = obcd_q;
  assign out_neg   = oneg_q;
  assign out_ovf   = oovf_q;
  assign out_blank = oblank_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench: two converters (5 and 3 digits) share stimulus and are
// compared against an arithmetic reference model.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [13:0] in_data;
  logic        in_signed;
  logic        out_ready;

  logic        rdy5, vld5, neg5, ovf5;
  logic [19:0] bcd5;
  logic [4:0]  blank5;
  logic        rdy3, vld3, neg3, ovf3;
  logic [11:0] bcd3;
  logic [2:0]  blank3;

  int n_checks = 0;
  int n_errors = 0;

  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(5)) u_dut5 (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy5), .in_data(in_data), .in_signed(in_signed),
    .out_valid(vld5), .out_ready(out_ready), .out_bcd(bcd5),
    .out_neg(neg5), .out_ovf(ovf5), .out_blank(blank5)
  );

  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(3)) u_dut3 (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy3), .in_data(in_data), .in_signed(in_signed),
    .out_valid(vld3), .out_ready(out_ready), .out_bcd(bcd3),
    .out_neg(neg3), .out_ovf(ovf3), .out_blank(blank3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: decimal arithmetic on the signed/unsigned value.
  task automatic model(input logic [13:0] d, input logic s, input int nd,
                       output logic [19:0] bcd, output logic neg,
                       output logic ovf, output logic [4:0] blank);
    longint m, p, q, r, pw;
    if (s && d[13]) begin
      m   = 64'd16384 - longint'(d);
      neg = 1'b1;
    end else begin
      m   = longint'(d);
      neg = 1'b0;
    end
    p = 1;
    for (int i = 0; i < nd; i++) p = p * 10;
    ovf   = (m >= p);
    q     = m % p;
    r     = q;
    bcd   = '0;
    blank = '0;
    pw    = 1;
    for (int i = 0; i < nd; i++) begin
      bcd[4*i +: 4] = 4'(r % 10);
      r = r / 10;
      if (i >= 1) blank[i] = (q < pw);
      pw = pw * 10;
    end
  endtask

  task automatic check_out(input string tag, input logic [13:0] d, input logic s);
    logic [19:0] eb;
    logic        en, eo;
    logic [4:0]  ebl;
    model(d, s, 5, eb, en, eo, ebl);
    check({tag, ".bcd5"},   bcd5,   eb);
    check({tag, ".neg5"},   neg5,   en);
    check({tag, ".ovf5"},   ovf5,   eo);
    check({tag, ".blank5"}, blank5, ebl);
    model(d, s, 3, eb, en, eo, ebl);
    check({tag, ".bcd3"},   bcd3,   eb[11:0]);
    check({tag, ".neg3"},   neg3,   en);
    check({tag, ".ovf3"},   ovf3,   eo);
    check({tag, ".blank3"}, blank3, ebl[2:0]);
  endtask

  // Called just after the acceptance edge; waits (bounded) for the result.
  task automatic wait_result(input string tag, input logic [13:0] d, input logic s);
    int lat;
    lat = 0;
    while (!vld5 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, lat, 14);
    check({tag, ".vld3"}, vld3, 1'b1);
    check_out(tag, d, s);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".vld_clr"}, vld5, 1'b0);
    check({tag, ".rdy_back"}, rdy5, 1'b1);
  endtask

  task automatic run_conv(input string tag, input logic [13:0] d, input logic s);
    check({tag, ".rdy"}, rdy5, 1'b1);
    in_valid  = 1'b1;
    in_data   = d;
    in_signed = s;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_data   = 14'($urandom);
    in_signed = 1'($urandom);
    check({tag, ".busy"}, rdy5, 1'b0);
    wait_result(tag, d, s);
    handshake(tag);
  endtask

  initial begin
    logic [13:0] rd;
    logic        rs;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_signed = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.rdy",   rdy5,   1'b1);
    check("rst.vld",   vld5,   1'b0);
    check("rst.bcd",   bcd5,   20'h0);
    check("rst.neg",   neg5,   1'b0);
    check("rst.ovf",   ovf5,   1'b0);
    check("rst.blank", blank5, 5'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_conv("u9999",  14'd9999,  1'b0);
    check("u9999.bcd_lit",   bcd5,   20'h09999);
    check("u9999.blank_lit", blank5, 5'b10000);
    run_conv("u16383", 14'd16383, 1'b0);
    check("u16383.bcd_lit",  bcd5,   20'h16383);
    run_conv("zero",   14'd0,     1'b0);
    check("zero.blank_lit",  blank5, 5'b11110);
    run_conv("s2000",  14'h2000,  1'b1);
    check("s2000.bcd_lit",   bcd5,   20'h08192);
    run_conv("s3fff",  14'h3FFF,  1'b1);
    check("s3fff.bcd_lit",   bcd5,   20'h00001);
    run_conv("s1fff",  14'h1FFF,  1'b1);
    check("s1fff.bcd_lit",   bcd5,   20'h08191);
    run_conv("o1234",  14'd1234,  1'b0);
    check("o1234.bcd3_lit",  bcd3,   12'h234);
    check("o1234.ovf3_lit",  ovf3,   1'b1);
    run_conv("o999",   14'd999,   1'b0);
    run_conv("o1000",  14'd1000,  1'b0);
    check("o1000.ovf3_lit",  ovf3,   1'b1);

    // Backpressure: result held while a new word waits on in_valid.
    in_valid = 1'b1; in_data = 14'd5678; in_signed = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result("bp", 14'd5678, 1'b0);
    in_valid = 1'b1; in_data = 14'h2ABC; in_signed = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("bp.vld_hold", vld5, 1'b1);
      check("bp.rdy_low",  rdy5, 1'b0);
      check("bp.bcd_hold", bcd5, 20'h05678);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp.vld_clr",  vld5, 1'b0);
    check("bp.rdy_back", rdy5, 1'b1);
    check("bp.bcd_keep", bcd5, 20'h05678);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp.taken", rdy5, 1'b0);
    wait_result("bp2", 14'h2ABC, 1'b1);
    handshake("bp2");

    // Reset at the fifth conversion step.
    in_valid = 1'b1; in_data = 14'd7777; in_signed = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mrst.vld",   vld5,   1'b0);
    check("mrst.rdy",   rdy5,   1'b1);
    check("mrst.bcd",   bcd5,   20'h0);
    check("mrst.blank", blank5, 5'b0);
    repeat (20) @(posedge clk);
    #1;
    check("mrst.no_result", vld5, 1'b0);
    run_conv("a4321", 14'd4321, 1'b0);
    check("a4321.bcd_lit", bcd5, 20'h04321);

    for (int n = 0; n < 40; n++) begin
      rd = 14'($urandom);
      rs = 1'($urandom);
      if (n == 0) rd = 14'h2000;
      run_conv($sformatf("rnd%0d", n), rd, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Parametrised sequential binary-to-BCD converter using shift-and-add-3 (double dabble), processing one input bit per clock. It generalises the fixed 14-bit/4-digit converter: width, digit count and signed mode are all configurable, and it adds a valid/ready handshake on both sides, overflow detection and a leading-zero blanking mask. It sits between arithmetic/measurement logic and the seven-segment display driver in the seg subsystem.

## Interface
Parameters:
- BIN_W, 14, width of binary input; legal range is ≥ 2.
- DIGITS, 5, number of BCD digits produced; legal range is ≥ 1.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- sys_rst_n  in  1  reset, synchronous and active-low (sampled on the sys_clk rising edge only).
- in_valid  in  1  input word available.
- in_ready  out  1  converter can accept a word.
- in_data  in  BIN_W  binary value.
- in_signed  in  1  treat in_data as two's complement; sampled with in_data.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_bcd  out  4*DIGITS  BCD result; digit i occupies bits [4i+3:4i], with digit 0 as units.
- out_neg  out  1  result is negative.
- out_ovf  out  1  magnitude ≥ 10^DIGITS; out_bcd then holds magnitude mod 10^DIGITS.
- out_blank  out  DIGITS  bit i=1 means digit i is a leading zero.

## Operation
- FSM states: IDLE, CONV, DONE.
- **Reset** (sys_rst_n low at a clock edge): state ← IDLE, bit counter ← 0, and the working register and all output registers are cleared.
  - Reset values: in_ready=1, out_valid=0, out_bcd=0, out_neg=0, out_ovf=0, out_blank=0.
  - Reset has priority over every other event, including a reset arriving mid-conversion. The conversion in progress is discarded with no partial result.
- **IDLE**: in_ready=1.
  - On in_valid && in_ready, latch the magnitude and sign, clear the BCD accumulator and the overflow sticky bit, set counter ← 0, and go to CONV.
  - Magnitude: if in_signed=1 and in_data[BIN_W-1]=1, magnitude = (~in_data + 1) taken as BIN_W-bit unsigned and neg=1. So -2^(BIN_W-1) gives magnitude 2^(BIN_W-1). Otherwise magnitude = in_data and neg=0.
- **CONV**: in_ready=0. Each cycle performs one step:
  - For each digit of the accumulator, a value > 4 gets +3 added (4-bit, no carry out).
  - The {accumulator, magnitude} register is then shifted left 1, MSB first.
  - The bit shifted out of the top of digit DIGITS-1 is ORed into the overflow sticky bit.
  - The counter increments. After BIN_W steps the FSM goes to DONE.
- **On entry to DONE**, the output registers are loaded:
  - out_bcd ← accumulator, out_neg ← neg, out_ovf ← sticky bit.
  - out_blank[0] ← 0. For i ≥ 1, out_blank[i] ← 1 iff digits i through DIGITS-1 are all 0.
  - out_valid ← 1.
- **DONE**: out_valid=1, in_ready=0. All outputs are held stable until out_ready=1. On out_valid && out_ready, out_valid ← 0 and state ← IDLE.
  - out_bcd, out_neg, out_ovf and out_blank keep their last value after the handshake; they change only at the next DONE entry or reset.
- in_valid and in_data are ignored outside IDLE. in_data may change freely once accepted.
- Zero input gives out_bcd=0, out_neg=0, out_blank = all ones except bit 0.

## Timing
- Acceptance edge E0 is the edge at which in_valid && in_ready is sampled.
- Conversion steps occur at edges E1..E_BIN_W. out_valid is high after edge E_BIN_W, so latency is BIN_W cycles.
- Output handshake at edge H: in_ready=1 during the cycle after H, and the earliest next acceptance is edge H+1.
  - Sustained throughput is one result per BIN_W+2 cycles when out_ready is held at 1.
- in_ready and out_valid are decoded from registered state, with no combinational path from in_valid or out_ready.
- Out-of-range parameters (BIN_W < 2 or DIGITS < 1) are a configuration error.

## Test plan
- **Unsigned, mid-range:** BIN_W=14, DIGITS=5, in_data=9999, in_signed=0 → out_bcd=20'h09999, out_neg=0, out_ovf=0, out_blank=5'b10000; out_valid rises exactly 14 cycles after acceptance.
- **Full scale and zero:** in_data=16383 → out_bcd=20'h16383, out_blank=5'b00000. in_data=0 → out_bcd=0, out_blank=5'b11110.
- **Signed:** in_signed=1, in_data=14'h2000 → out_neg=1, out_bcd=20'h08192. in_data=14'h3FFF → out_neg=1, out_bcd=20'h00001, out_blank=5'b11110. in_data=14'h1FFF → out_neg=0, out_bcd=20'h08191.
- **Overflow:** DIGITS=3, BIN_W=14: 1234 → out_bcd=12'h234, out_ovf=1. 999 → out_bcd=12'h999, out_ovf=0. 1000 → out_bcd=12'h000, out_ovf=1.
- **Backpressure:** hold out_ready=0 for 10 cycles after out_valid with in_valid=1 and new in_data → outputs stable, in_ready=0, new word not taken. Raise out_ready → handshake, in_ready=1 the next cycle, and the new word is converted correctly.
- **Reset mid-conversion:** assert sys_rst_n=0 for one edge at step 5 of a conversion → after that edge out_valid=0, in_ready=1, out_bcd=0. The following conversion of 4321 yields 20'h04321.
